popcount_sequencer: RTL

Multi-cycle population-count controller that shares one narrow `counting_ones` datapath across a wide input word. It accepts a DATA_WIDTH word on a valid/ready handshake. It then feeds the word to a CHUNK_WIDTH-bit `counting_ones` instance one chunk per cycle, LSB chunk first, and accumulates the partial counts. The total is returned on a second valid/ready handshake. It sits between a streaming producer and consumer wherever a full-width combinational popcount is too large or too slow.

---
 rtl/popcount_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/popcount_sequencer.sv
// popcount_sequencer: multi-cycle population count that reuses one narrow
// counting_ones datapath across a wide input word, one chunk per cycle,
// least significant chunk first. Words arrive and results leave on
// valid/ready handshakes.
//
// Optional feature: define POPCOUNT_SEQ_EARLY_EXIT_EN to finish as soon as
// the remaining unprocessed bits are all zero. This makes latency
// data-dependent, but the counts stay the same.

// counting_ones: combinational popcount of a CHUNK_WIDTH-bit slice.
module counting_ones #(
  parameter int CHUNK_WIDTH = 8,
  parameter int PW          = $clog2(CHUNK_WIDTH) + 1
) (
  input  logic [CHUNK_WIDTH-1:0] i_data,
  output logic [PW-1:0]          o_count
);

  // Sum the individual bits of the slice
  always_comb begin
    o_count = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      o_count = o_count + PW'(i_data[i]);
    end
  end

endmodule

module popcount_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(DATA_WIDTH):0]   dout,
  output logic                          busy
);

  localparam int N  = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam int PW = $clog2(CHUNK_WIDTH) + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_sh;
  logic [CW-1:0]         r_acc;
  logic [IW-1:0]         r_idx;

  logic [PW-1:0]         w_chunkCount;
  logic [CW-1:0]         w_accNext;
  logic                  w_lastChunk;

  counting_ones #(
    .CHUNK_WIDTH (CHUNK_WIDTH),
    .PW          (PW)
  ) u_countingOnes (
    .i_data  (r_sh[CHUNK_WIDTH-1:0]),
    .o_count (w_chunkCount)
  );

  // Running total including the chunk being processed this cycle
  assign w_accNext = r_acc + CW'(w_chunkCount);

`ifdef POPCOUNT_SEQ_EARLY_EXIT_EN
  logic [DATA_WIDTH-1:0] w_remainder;

  // Bits still waiting after the current chunk; all-zero means we can stop
  assign w_remainder = r_sh >> CHUNK_WIDTH;
  assign w_lastChunk = (r_idx == IW'(N - 1)) || (w_remainder == '0);
`else
  // Fixed latency: stop only after the most significant chunk
  assign w_lastChunk = (r_idx == IW'(N - 1));
`endif

  // Control FSM with registered handshake outputs and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_sh      <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      dout      <= '0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sh     <= din;
            r_acc    <= '0;
            r_idx    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef POPCOUNT_SEQ_EARLY_EXIT_EN
            if (din == '0) begin
              r_state   <= DONE;
              out_valid <= 1'b1;
              dout      <= '0;
            end else begin
              r_state <= BUSY;
            end
`else
            r_state <= BUSY;
`endif
          end
        end

        BUSY: begin
          r_acc <= w_accNext;
          r_sh  <= r_sh >> CHUNK_WIDTH;
          r_idx <= r_idx + IW'(1);
          if (w_lastChunk) begin
            r_state   <= DONE;
            out_valid <= 1'b1;
            dout      <= w_accNext;
          end
        end

        DONE: begin
          if (out_ready) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          r_state   <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
